// File: rtl/pixel_window_if.sv
// Raster pixel stream in, WIN x WIN window stream out, for pixel_window_param.
// master = pixel source / window consumer side, slave = the window generator.
interface pixel_window_if #(
    parameter int DATA_W = 8,
    parameter int WIN    = 5
);
    logic                       h_sync_i;
    logic                       v_sync_i;
    logic [DATA_W-1:0]          incoming_pixel;
    logic                       pixel_valid_input;
    logic [WIN*WIN*DATA_W-1:0]  out_pixel;
    logic                       pixel_valid_output;
    logic                       h_sync_o;
    logic                       v_sync_o;
    logic                       overflow_o;

    modport master (
        output h_sync_i, v_sync_i, incoming_pixel, pixel_valid_input,
        input  out_pixel, pixel_valid_output, h_sync_o, v_sync_o, overflow_o
    );

    modport slave (
        input  h_sync_i, v_sync_i, incoming_pixel, pixel_valid_input,
        output out_pixel, pixel_valid_output, h_sync_o, v_sync_o, overflow_o
    );
endinterface

// File: rtl/pixel_window_param.sv
// Sliding WIN x WIN window generator with VALID / ZERO border handling.
// Window registered 1 cycle after the accepting edge; no backpressure (1 pixel per clk).
module pixel_window_param #(
    parameter int DATA_W      = 8,
    parameter int WIN         = 5,
    parameter int MAX_LINE    = 2048,
    parameter int ADDR_W      = 11,
    parameter int BORDER_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    pixel_window_if.slave pif
);
    localparam int CW  = ADDR_W + 1;
    localparam int RAW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam int WW  = WIN * WIN * DATA_W;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]     col_q, col_d, col_eff;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              had_q, had_d, ovf_q, ovf_d;
    logic              sync, take, drop, accept, win_vld;
    logic [RAW-1:0]    addr;

    logic [DATA_W-1:0] rd    [WIN-1];
    logic [DATA_W-1:0] wdat  [WIN-1];
    logic [DATA_W-1:0] colv  [WIN];
    logic [DATA_W-1:0] win_q [WIN][WIN];
    logic [DATA_W-1:0] win_d [WIN][WIN];
    logic [WW-1:0]     masked, out_q;
    logic              vld_q, hs_q, vs_q;

    // Syncs are applied before the pixel of the same cycle, so the pixel sees
    // the post-sync row/column (col_eff, row_d) and a v_sync lifts IDLE at once.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        had_d   = had_q;
        ovf_d   = ovf_q;
        sync    = pif.h_sync_i | pif.v_sync_i;
        col_eff = sync ? '0 : col_q;
        if (pif.v_sync_i) begin
            state_d = ACTIVE;
            row_d   = '0;
            had_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (pif.h_sync_i) begin
            had_d = 1'b0;
            if (had_q && row_q != '1)
                row_d = row_q + ADDR_W'(1);
        end
        take   = pif.pixel_valid_input && (state_d == ACTIVE);
        drop   = take && (col_eff == CW'(MAX_LINE));
        accept = take && !drop;
        col_d  = accept ? col_eff + CW'(1) : col_eff;
        if (accept)
            had_d = 1'b1;
        if (drop)
            ovf_d = 1'b1;
        win_vld = (BORDER_MODE == 1) ||
                  ((row_d >= ADDR_W'(WIN - 1)) && (col_eff >= CW'(WIN - 1)));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign addr = col_eff[RAW-1:0];

    always_comb begin
        wdat[0] = pif.incoming_pixel;
        for (int k = 1; k < WIN - 1; k++)
            wdat[k] = rd[k-1];
    end

    // Cascaded line buffers: RAM k holds the line k+1 above the current one.
    for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
        logic [DATA_W-1:0] mem [MAX_LINE];
        assign rd[k] = mem[addr];
        always_ff @(posedge clk) begin
            if (accept)
                mem[addr] <= wdat[k];
        end
    end

    always_comb begin
        colv[WIN-1] = pif.incoming_pixel;
        for (int dy = 0; dy < WIN - 1; dy++)
            colv[dy] = rd[WIN-2-dy];
        for (int dy = 0; dy < WIN; dy++) begin
            for (int dx = 0; dx < WIN - 1; dx++)
                win_d[dy][dx] = win_q[dy][dx+1];
            win_d[dy][WIN-1] = colv[dy];
        end
    end

    // Out-of-image taps are masked by position, so stale RAM or shift data never leaks.
    always_comb begin
        masked = '0;
        for (int dy = 0; dy < WIN; dy++) begin
            for (int dx = 0; dx < WIN; dx++) begin
                masked[(dy*WIN+dx)*DATA_W +: DATA_W] = win_d[dy][dx];
                if ((BORDER_MODE == 1) &&
                    ((row_d < ADDR_W'(WIN - 1 - dy)) || (col_eff < CW'(WIN - 1 - dx))))
                    masked[(dy*WIN+dx)*DATA_W +: DATA_W] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            win_q <= win_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
            had_q <= 1'b0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            out_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            had_q <= had_d;
            ovf_q <= ovf_d;
            vld_q <= accept && win_vld;
            hs_q  <= pif.h_sync_i;
            vs_q  <= pif.v_sync_i;
            if (accept && win_vld)
                out_q <= masked;
        end
    end

    assign pif.out_pixel          = out_q;
    assign pif.pixel_valid_output = vld_q;
    assign pif.h_sync_o           = hs_q;
    assign pif.v_sync_o           = vs_q;
    assign pif.overflow_o         = ovf_q;
endmodule

// File: tb/tb_pixel_window_param.sv
// Drives one raster stream into VALID, ZERO and short-line (MAX_LINE=4) instances
// and compares each against an image-array reference model every cycle.
module tb_pixel_window_param;
    localparam int DW = 8;
    localparam int W  = 3;
    localparam int WW = W * W * DW;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          hs  = 1'b0;
    logic          vs  = 1'b0;
    logic          pv  = 1'b0;
    logic [DW-1:0] px  = '0;

    pixel_window_if #(.DATA_W(DW), .WIN(W)) if_v ();
    pixel_window_if #(.DATA_W(DW), .WIN(W)) if_z ();
    pixel_window_if #(.DATA_W(DW), .WIN(W)) if_o ();

    assign if_v.h_sync_i = hs;  assign if_v.v_sync_i = vs;
    assign if_v.pixel_valid_input = pv;  assign if_v.incoming_pixel = px;
    assign if_z.h_sync_i = hs;  assign if_z.v_sync_i = vs;
    assign if_z.pixel_valid_input = pv;  assign if_z.incoming_pixel = px;
    assign if_o.h_sync_i = hs;  assign if_o.v_sync_i = vs;
    assign if_o.pixel_valid_input = pv;  assign if_o.incoming_pixel = px;

    pixel_window_param #(.DATA_W(DW), .WIN(W), .MAX_LINE(2048), .ADDR_W(11), .BORDER_MODE(0))
        dut_v (.clk(clk), .rst(rst), .pif(if_v.slave));
    pixel_window_param #(.DATA_W(DW), .WIN(W), .MAX_LINE(2048), .ADDR_W(11), .BORDER_MODE(1))
        dut_z (.clk(clk), .rst(rst), .pif(if_z.slave));
    pixel_window_param #(.DATA_W(DW), .WIN(W), .MAX_LINE(4), .ADDR_W(4), .BORDER_MODE(1))
        dut_o (.clk(clk), .rst(rst), .pif(if_o.slave));

    logic [WW-1:0] o_win [NI];
    logic          o_vld [NI];
    logic          o_hs  [NI];
    logic          o_vs  [NI];
    logic          o_ovf [NI];
    assign o_win[0] = if_v.out_pixel;  assign o_vld[0] = if_v.pixel_valid_output;
    assign o_hs[0]  = if_v.h_sync_o;   assign o_vs[0]  = if_v.v_sync_o;  assign o_ovf[0] = if_v.overflow_o;
    assign o_win[1] = if_z.out_pixel;  assign o_vld[1] = if_z.pixel_valid_output;
    assign o_hs[1]  = if_z.h_sync_o;   assign o_vs[1]  = if_z.v_sync_o;  assign o_ovf[1] = if_z.overflow_o;
    assign o_win[2] = if_o.out_pixel;  assign o_vld[2] = if_o.pixel_valid_output;
    assign o_hs[2]  = if_o.h_sync_o;   assign o_vs[2]  = if_o.v_sync_o;  assign o_ovf[2] = if_o.overflow_o;

    // Reference model: per-instance frame image plus raster position.
    int m_maxl [NI] = '{2048, 2048, 4};
    int m_rmax [NI] = '{2047, 2047, 15};
    bit m_zero [NI] = '{1'b0, 1'b1, 1'b1};
    bit m_act  [NI];
    bit m_had  [NI];
    bit m_ovf  [NI];
    int m_row  [NI];
    int m_col  [NI];
    logic [DW-1:0] img [NI][16][16];
    logic [WW-1:0] e_win [NI];
    bit            e_vld [NI];
    bit            e_hs, e_vs;
    int            vcount [NI];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] ref_window(input int i, input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int dy = 0; dy < W; dy++)
            for (int dx = 0; dx < W; dx++) begin
                int rr = r - (W - 1 - dy);
                int cc = c - (W - 1 - dx);
                if (rr >= 0 && cc >= 0)
                    w[(dy*W+dx)*DW +: DW] = img[i][rr][cc];
            end
        return w;
    endfunction

    // Window of the row*16+col test pattern anchored at (r,c), all taps in-image.
    function automatic logic [WW-1:0] pattern_window(input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int dy = 0; dy < W; dy++)
            for (int dx = 0; dx < W; dx++)
                w[(dy*W+dx)*DW +: DW] = 8'((r - W + 1 + dy) * 16 + (c - W + 1 + dx));
        return w;
    endfunction

    task automatic model_step(input bit rn, input bit h, input bit v, input bit p, input logic [DW-1:0] d);
        e_hs = rn & h;
        e_vs = rn & v;
        for (int i = 0; i < NI; i++) begin
            if (!rn) begin
                m_act[i] = 0; m_had[i] = 0; m_ovf[i] = 0; m_row[i] = 0; m_col[i] = 0;
                e_vld[i] = 0; e_win[i] = '0;
            end else begin
                if (v) begin
                    m_act[i] = 1; m_row[i] = 0; m_col[i] = 0; m_had[i] = 0; m_ovf[i] = 0;
                end else if (h) begin
                    if (m_had[i] && m_row[i] < m_rmax[i]) m_row[i]++;
                    m_col[i] = 0; m_had[i] = 0;
                end
                e_vld[i] = 0;
                if (p && m_act[i]) begin
                    if (m_col[i] == m_maxl[i]) begin
                        m_ovf[i] = 1;
                    end else begin
                        img[i][m_row[i]][m_col[i]] = d;
                        m_had[i] = 1;
                        if (m_zero[i] || (m_row[i] >= W - 1 && m_col[i] >= W - 1)) begin
                            e_vld[i] = 1;
                            e_win[i] = ref_window(i, m_row[i], m_col[i]);
                        end
                        m_col[i]++;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rn, input bit h, input bit v, input bit p, input logic [DW-1:0] d);
        rst = rn; hs = h; vs = v; pv = p; px = d;
        @(posedge clk);
        model_step(rn, h, v, p, d);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("vld%0d", i), WW'(o_vld[i]), WW'(e_vld[i]));
            check($sformatf("win%0d", i), o_win[i], e_win[i]);
            check($sformatf("hs%0d", i),  WW'(o_hs[i]),  WW'(e_hs));
            check($sformatf("vs%0d", i),  WW'(o_vs[i]),  WW'(e_vs));
            check($sformatf("ovf%0d", i), WW'(o_ovf[i]), WW'(m_ovf[i]));
            if (o_vld[i]) vcount[i]++;
        end
    endtask

    // pat: 0 = row*16+col, 1 = all 0xFF, 2 = random. Optional reset at (rst_r,rst_c).
    task automatic frame(input int rows, input int cols, input int pat, input int gap_pct,
                         input bit coinc, input int rst_r = -1, input int rst_c = -1);
        for (int r = 0; r < rows; r++) begin
            if (!coinc) step(1, r > 0, r == 0, 0, 8'($urandom));
            for (int c = 0; c < cols; c++) begin
                logic [DW-1:0] d;
                bit first;
                if (c > 0 && $urandom_range(99) < gap_pct) step(1, 0, 0, 0, 8'($urandom));
                d = (pat == 0) ? 8'(r * 16 + c) : (pat == 1) ? 8'hFF : 8'($urandom);
                first = coinc && (c == 0);
                if (r == rst_r && c == rst_c) begin
                    step(0, 0, 0, 1, d);
                    return;
                end
                step(1, first && r > 0, first && r == 0, 1, d);
            end
        end
        step(1, 0, 0, 0, 8'h00);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NI; i++) vcount[i] = 0;
    endtask

    initial begin
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 1, 8'h55);
        check("rst_win", o_win[1], '0);
        check("rst_vld", WW'(o_vld[0]), '0);

        // Pixels and an h_sync before the first v_sync are ignored.
        clear_counts();
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 8'($urandom));
        step(1, 1, 0, 1, 8'h77);
        step(1, 0, 0, 1, 8'h78);
        check("pre_frame_cnt", WW'(vcount[0] + vcount[1] + vcount[2]), '0);

        clear_counts();
        frame(4, 4, 0, 0, 1);
        check("cnt_valid", WW'(vcount[0]), WW'(4));
        check("cnt_zero",  WW'(vcount[1]), WW'(16));
        check("cnt_short", WW'(vcount[2]), WW'(16));
        check("last_win_valid", o_win[0], pattern_window(3, 3));
        check("last_win_zero",  o_win[1], pattern_window(3, 3));

        frame(3, 5, 1, 0, 0);
        frame(3, 6, 0, 10, 1);
        check("ovf_set",  WW'(o_ovf[2]), WW'(1));
        check("ovf_wide", WW'(o_ovf[0]), '0);
        repeat (3) step(1, 0, 0, 0, 8'h00);
        check("ovf_hold", WW'(o_ovf[2]), WW'(1));
        step(1, 0, 1, 0, 8'h00);
        check("ovf_clr",  WW'(o_ovf[2]), '0);

        frame(4, 4, 0, 0, 1, 2, 1);
        check("midrst_win", o_win[0], '0);
        check("midrst_vld", WW'(o_vld[1]), '0);
        clear_counts();
        for (int k = 0; k < 5; k++) step(1, k == 2, 0, 1, 8'($urandom));
        check("midrst_ignored", WW'(vcount[0] + vcount[1] + vcount[2]), '0);
        frame(4, 4, 0, 0, 1);
        check("restart_cnt", WW'(vcount[0]), WW'(4));
        check("restart_win", o_win[0], pattern_window(3, 3));

        for (int f = 0; f < 12; f++)
            frame($urandom_range(3, 8), $urandom_range(3, 12), 2, 20, 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
